// File: rtl/branch_pkg.sv
// Shared BrOp field positions, conditional funct codes and BHT counter helpers
// for the branch resolve unit.
package branch_pkg;

  localparam int unsigned BROP_JUMP_BIT = 4;
  localparam int unsigned BROP_COND_BIT = 3;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_RESET = 2'b01;
  localparam bht_ctr_t CTR_MAX   = 2'b11;
  localparam bht_ctr_t CTR_MIN   = 2'b00;

  // Saturating 2-bit counter step; never wraps at either end.
  function automatic bht_ctr_t ctr_update(input bht_ctr_t c, input logic inc);
    if (inc) return (c == CTR_MAX) ? c : c + 2'd1;
    return (c == CTR_MIN) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational BrOp decoder/comparator: jump, conditional compare, or no branch.
// Unsupported conditional functs resolve not-taken with illegal raised.
module branch_compare
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      brop,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (brop[BROP_JUMP_BIT]) begin
      taken = 1'b1;
    end else if (brop[BROP_COND_BIT]) begin
      case (brop[2:0])
        BR_EQ:   taken = (a == b);
        BR_NE:   taken = (a != b);
        BR_LT:   taken = ($signed(a) <  $signed(b));
        BR_GE:   taken = ($signed(a) >= $signed(b));
        BR_LTU:  taken = (a <  b);
        BR_GEU:  taken = (a >= b);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a 2-bit saturating BHT direction predictor.
// Optional performance counters are built only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [4:0]       brop_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  output logic             res_valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t         bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             is_jump;
  logic             cond_ok;
  logic             accept;
  logic             lookup;
  logic             mispredict;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc_i[IDX_W+1:2];
  assign res_idx        = res_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_i, res_pc_i};

  branch_compare #(.XLEN(XLEN)) u_compare (
    .a       (a_i),
    .b       (b_i),
    .brop    (brop_i),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign accept     = res_valid_i & ~flush_i;
  assign lookup     = pred_valid_i & ~flush_i;
  assign is_jump    = brop_i[BROP_JUMP_BIT];
  assign cond_ok    = ~is_jump & brop_i[BROP_COND_BIT] & ~cmp_illegal;
  assign mispredict = is_jump ? ~pred_taken_i
                    : cond_ok ? (cmp_taken ^ pred_taken_i) : 1'b0;

  // Prediction holds its last sampled value while no lookup is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
    end else begin
      pred_valid_o <= lookup;
      if (lookup) pred_taken_o <= bht[pred_idx][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_o  <= 1'b0;
      taken_o      <= 1'b0;
      mispredict_o <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      res_valid_o  <= accept;
      taken_o      <= accept & cmp_taken;
      mispredict_o <= accept & mispredict;
      illegal_o    <= accept & cmp_illegal;
    end
  end

  // Lookup reads the pre-edge array, so a same-index update is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
    end else if (accept && cond_ok) begin
      bht[res_idx] <= ctr_update(bht[res_idx], cmp_taken);
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (accept && cond_ok) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; counter expectations
// follow BRU_PERF_CNT_EN (saturating 4-bit counters when defined, zero otherwise).
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
`ifdef BRU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] BEQ  = 5'b01000, BNE  = 5'b01001, BLT  = 5'b01100;
  localparam logic [4:0] BGE  = 5'b01101, BLTU = 5'b01110, BGEU = 5'b01111;
  localparam logic [4:0] ILL2 = 5'b01010, ILL3 = 5'b01011, JAL  = 5'b10000;
  localparam logic [4:0] NOP0 = 5'b00000, NOP7 = 5'b00111;
  localparam logic [31:0] M1  = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pred_valid_i, pred_valid_o, pred_taken_o;
  logic [XLEN-1:0]  pred_pc_i, res_pc_i, a_i, b_i;
  logic             res_valid_i, pred_taken_i, flush_i;
  logic [4:0]       brop_i;
  logic             res_valid_o, taken_o, mispredict_o, illegal_o;
  logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;

  logic [3:0] rv;
  logic [1:0] pv;
  assign rv = {res_valid_o, taken_o, mispredict_o, illegal_o};
  assign pv = {pred_valid_o, pred_taken_o};

  int vectors    = 0;
  int miscompares = 0;
  int br_n = 0;
  int mp_n = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .a_i              (a_i),
    .b_i              (b_i),
    .brop_i           (brop_i),
    .pred_taken_i     (pred_taken_i),
    .flush_i          (flush_i),
    .res_valid_o      (res_valid_o),
    .taken_o          (taken_o),
    .mispredict_o     (mispredict_o),
    .illegal_o        (illegal_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    if (!PERF) return '0;
    return (n >= (1 << CNT_W) - 1) ? '1 : CNT_W'(n);
  endfunction

  task automatic idle();
    pred_valid_i = 1'b0; pred_pc_i = '0; res_valid_i = 1'b0; res_pc_i = '0;
    a_i = '0; b_i = '0; brop_i = '0; pred_taken_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] op, input logic pt);
    res_valid_i = 1'b1; res_pc_i = pc; a_i = a; b_i = b; brop_i = op; pred_taken_i = pt;
  endtask

  task automatic lkp(input logic [31:0] pc);
    pred_valid_i = 1'b1; pred_pc_i = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    vectors++;
    if ({rv, pv} !== 6'b0) begin
      miscompares++; $display("FAIL reset_outs: got %b expected %b", {rv, pv}, 6'b0);
    end
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== '0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
    end
    #10 rst_n = 1'b1;
    lkp(32'h100);
    tick();
    vectors++;
    if ({pv, rv} !== 6'b10_0000) begin
      miscompares++; $display("FAIL first_lookup: got %b expected %b", {pv, rv}, 6'b10_0000);
    end
    idle();
  endtask

  task automatic test_blt_saturate();
    for (int i = 0; i < 3; i++) begin
      res(32'h100, M1, 32'd1, BLT, 1'b0);
      tick();
      br_n++; mp_n++;
      vectors++;
      if (rv !== 4'b1110) begin
        miscompares++; $display("FAIL blt_res[%0d]: got %b expected 1110", i, rv);
      end
      idle();
      lkp(32'h100);
      tick();
      vectors++;
      if ({pv, rv} !== 6'b11_0000) begin
        miscompares++; $display("FAIL blt_lookup[%0d]: got %b expected 110000", i, {pv, rv});
      end
      idle();
    end
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL blt_cnt: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  // Walks entry 0 from 11 down through the 00 floor and back up, ending at 01.
  localparam logic [4:0] DEC_OP [7] = '{BGE, BGE, BGE, BGE, BLT, BLT, BGE};
  localparam logic       DEC_PT [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] DEC_RV [7] = '{4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1110, 4'b1110, 4'b1000};
  localparam logic       DEC_PR [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_counter_walk();
    for (int i = 0; i < 7; i++) begin
      res(32'h100, M1, 32'd1, DEC_OP[i], DEC_PT[i]);
      tick();
      br_n++;
      if (DEC_RV[i][1]) mp_n++;
      vectors++;
      if (rv !== DEC_RV[i]) begin
        miscompares++; $display("FAIL walk_res[%0d]: got %b expected %b", i, rv, DEC_RV[i]);
      end
      idle();
      lkp(32'h100);
      tick();
      vectors++;
      if (pv !== {1'b1, DEC_PR[i]}) begin
        miscompares++; $display("FAIL walk_lookup[%0d]: got %b expected %b", i, pv, {1'b1, DEC_PR[i]});
      end
      idle();
    end
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL walk_cnt: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  // 0x200 shares entry 0 with 0x100 at 64 entries; entry 0 holds 01 here.
  task automatic test_read_before_write();
    res(32'h200, 32'd5, 32'd5, BEQ, 1'b0);
    lkp(32'h200);
    tick();
    br_n++; mp_n++;
    vectors++;
    if ({pv, rv} !== 6'b10_1110) begin
      miscompares++; $display("FAIL rbw_same_cycle: got %b expected 101110", {pv, rv});
    end
    idle();
    lkp(32'h200);
    tick();
    vectors++;
    if (pv !== 2'b11) begin
      miscompares++; $display("FAIL rbw_next: got %b expected 11", pv);
    end
    idle();
    lkp(32'h104);
    tick();
    vectors++;
    if (pv !== 2'b10) begin
      miscompares++; $display("FAIL other_index: got %b expected 10", pv);
    end
    idle();
  endtask

  localparam logic [4:0]  CMP_OP [5] = '{BGEU, BLTU, BNE, BLT, BEQ};
  localparam logic [31:0] CMP_A  [5] = '{M1, M1, 32'd5, 32'd1, 32'd5};
  localparam logic [31:0] CMP_B  [5] = '{32'd1, 32'd1, 32'd5, M1, 32'd6};
  localparam logic        CMP_PT [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [3:0]  CMP_RV [5] = '{4'b1110, 4'b1000, 4'b1010, 4'b1000, 4'b1000};

  task automatic test_compares();
    for (int i = 0; i < 5; i++) begin
      res(32'h10C, CMP_A[i], CMP_B[i], CMP_OP[i], CMP_PT[i]);
      tick();
      br_n++;
      if (CMP_RV[i][1]) mp_n++;
      vectors++;
      if (rv !== CMP_RV[i]) begin
        miscompares++; $display("FAIL cmp[%0d] op=%b: got %b expected %b", i, CMP_OP[i], rv, CMP_RV[i]);
      end
      idle();
    end
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL cmp_cnt: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  // Entry 0 holds 10; a not-taken update leaking through the flush would drop it to 01.
  task automatic test_flush();
    res(32'h100, M1, 32'd1, BGE, 1'b1);
    lkp(32'h100);
    flush_i = 1'b1;
    tick();
    vectors++;
    if ({pv, rv} !== 6'b00_0000) begin
      miscompares++; $display("FAIL flush_outs: got %b expected 000000", {pv, rv});
    end
    idle();
    lkp(32'h100);
    tick();
    vectors++;
    if (pv !== 2'b11) begin
      miscompares++; $display("FAIL flush_bht: got %b expected 11", pv);
    end
    idle();
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  task automatic test_illegal();
    res(32'h100, 32'd5, 32'd6, ILL2, 1'b1);
    tick();
    vectors++;
    if (rv !== 4'b1001) begin
      miscompares++; $display("FAIL illegal_010: got %b expected 1001", rv);
    end
    res(32'h100, 32'd5, 32'd5, ILL3, 1'b1);
    tick();
    vectors++;
    if (rv !== 4'b1001) begin
      miscompares++; $display("FAIL illegal_011: got %b expected 1001", rv);
    end
    idle();
    lkp(32'h100);
    tick();
    vectors++;
    if (pv !== 2'b11) begin
      miscompares++; $display("FAIL illegal_bht: got %b expected 11", pv);
    end
    idle();
  endtask

  localparam logic [4:0] JMP_OP [4] = '{JAL, JAL, NOP0, NOP7};
  localparam logic       JMP_PT [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [3:0] JMP_RV [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b1000};

  // Entry 1 (pc 0x104) is still 01; any update from these would flip the prediction.
  task automatic test_jump_nonbranch();
    for (int i = 0; i < 4; i++) begin
      res(32'h104, 32'd3, 32'd3, JMP_OP[i], JMP_PT[i]);
      tick();
      vectors++;
      if (rv !== JMP_RV[i]) begin
        miscompares++; $display("FAIL jump[%0d] op=%b: got %b expected %b", i, JMP_OP[i], rv, JMP_RV[i]);
      end
      idle();
    end
    lkp(32'h104);
    tick();
    vectors++;
    if (pv !== 2'b10) begin
      miscompares++; $display("FAIL jump_bht: got %b expected 10", pv);
    end
    idle();
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL jump_cnt: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      res(32'h108, M1, 32'd1, BLT, 1'b0);
      tick();
      br_n++; mp_n++;
      vectors++;
      if (rv !== 4'b1110) begin
        miscompares++; $display("FAIL b2b_res[%0d]: got %b expected 1110", i, rv);
      end
    end
    idle();
    vectors++;
    if ({branch_cnt_o, mispredict_cnt_o} !== {exp_cnt(br_n), exp_cnt(mp_n)}) begin
      miscompares++; $display("FAIL b2b_cnt_sat: got %0d/%0d expected %0d/%0d",
        branch_cnt_o, mispredict_cnt_o, exp_cnt(br_n), exp_cnt(mp_n));
    end
  endtask

  task automatic test_reset_midop();
    res(32'h100, M1, 32'd1, BLT, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rv, pv, branch_cnt_o, mispredict_cnt_o} !== '0) begin
      miscompares++; $display("FAIL midop_reset: got %b/%0d/%0d expected 0",
        {rv, pv}, branch_cnt_o, mispredict_cnt_o);
    end
    idle();
    #2 rst_n = 1'b1;
    lkp(32'h100);
    tick();
    vectors++;
    if (pv !== 2'b10) begin
      miscompares++; $display("FAIL midop_bht: got %b expected 10", pv);
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_blt_saturate();
    test_counter_walk();
    test_read_before_write();
    test_compares();
    test_flush();
    test_illegal();
    test_jump_nonbranch();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
